// File: rtl/rgb_decoder.sv
// rgb_decoder: thresholds 24-bit RGB pixels into a 3-bit colour code
// through one registered valid/ready stage, with saturating statistics.
module rgb_decoder #(
  parameter int THRESH = 128,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [23:0]      rgb_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       colour_out,
  output logic             exact,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_count,
  output logic [CNT_W-1:0] pix_count,
  output logic [CNT_W-1:0] inexact_count
);

  localparam logic [7:0]       TH      = 8'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0] r, g, b;
  logic       accept;
  logic [2:0] nx_colour;
  logic       nx_exact;

  assign r = rgb_in[23:16];
  assign g = rgb_in[15:8];
  assign b = rgb_in[7:0];

  function automatic logic rail(input logic [7:0] v);
    return (v == 8'h00) || (v == 8'hFF);
  endfunction

  assign nx_colour = {r >= TH, g >= TH, b >= TH};
  assign nx_exact  = rail(r) & rail(g) & rail(b);

  // rst term keeps the source stalled while the block is held in reset
  assign in_ready = !rst & enable & (!out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour_out <= '0;
      exact      <= 1'b0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      colour_out <= nx_colour;
      exact      <= nx_exact;
      out_valid  <= 1'b1;
    end else if (enable & out_valid & out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_count     <= '0;
      inexact_count <= '0;
    end else if (clr_count) begin
      pix_count     <= '0;
      inexact_count <= '0;
    end else if (accept) begin
      if (pix_count != CNT_MAX)
        pix_count <= pix_count + 1'b1;
      if (!nx_exact && inexact_count != CNT_MAX)
        inexact_count <= inexact_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_decoder.sv
// tb_rgb_decoder: directed checks of rgb_decoder, including a
// CNT_W=4 instance for saturation and a converter loopback model.
module tb_rgb_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] rgb_in;
  logic        in_valid;
  logic        out_ready;
  logic        clr_count;

  logic        in_ready, exact, out_valid;
  logic [2:0]  colour_out;
  logic [15:0] pix_count, inexact_count;

  logic        in_ready4, exact4, out_valid4;
  logic [2:0]  colour_out4;
  logic [3:0]  pix_count4, inexact_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_decoder #(.THRESH(128), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .rgb_in(rgb_in), .in_valid(in_valid),
    .in_ready(in_ready), .colour_out(colour_out),
    .exact(exact), .out_valid(out_valid),
    .out_ready(out_ready), .clr_count(clr_count),
    .pix_count(pix_count), .inexact_count(inexact_count)
  );

  rgb_decoder #(.THRESH(128), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable),
    .rgb_in(rgb_in), .in_valid(in_valid),
    .in_ready(in_ready4), .colour_out(colour_out4),
    .exact(exact4), .out_valid(out_valid4),
    .out_ready(out_ready), .clr_count(clr_count),
    .pix_count(pix_count4), .inexact_count(inexact_count4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference RGB converter: code bit -> full-scale channel
  function automatic logic [23:0] conv(input logic [2:0] c);
    logic [23:0] p;
    p[23:16] = c[2] ? 8'hFF : 8'h00;
    p[15:8]  = c[1] ? 8'hFF : 8'h00;
    p[7:0]   = c[0] ? 8'hFF : 8'h00;
    return p;
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; rgb_in = '0;
    in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_colour", 32'(colour_out), 0);
    chk("rst_exact", 32'(exact), 0);
    chk("rst_pix", 32'(pix_count), 0);
    chk("rst_inexact", 32'(inexact_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rgb_in = conv(3'(i)); in_valid = 1'b1;
      tick();
      chk("loop_colour", 32'(colour_out), i);
      chk("loop_exact", 32'(exact), 1);
      chk("loop_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_hold", 32'(colour_out), 7);
    chk("loop_pix", 32'(pix_count), 8);
    chk("loop_inexact", 32'(inexact_count), 0);

    rgb_in = 24'h7F8080; in_valid = 1'b1;
    tick();
    chk("th_a_colour", 32'(colour_out), 3);
    chk("th_a_exact", 32'(exact), 0);
    rgb_in = 24'h80007F;
    tick();
    chk("th_b_colour", 32'(colour_out), 4);
    chk("th_b_exact", 32'(exact), 0);
    in_valid = 1'b0;
    tick();
    chk("th_inexact", 32'(inexact_count), 2);
    chk("th_pix", 32'(pix_count), 10);

    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("clr_pix", 32'(pix_count), 0);
    out_ready = 1'b0; rgb_in = 24'h0000FF; in_valid = 1'b1;
    tick();
    chk("bp_first", 32'(colour_out), 1);
    rgb_in = 24'hFFFFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      tick();
      chk("bp_colour", 32'(colour_out), 1);
      chk("bp_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    tick();
    chk("bp_next", 32'(colour_out), 7);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 0);
    chk("bp_pix", 32'(pix_count), 2);

    rgb_in = 24'hFF0000; in_valid = 1'b1;
    tick();
    chk("en_pre", 32'(colour_out), 4);
    enable = 1'b0; rgb_in = 24'h00FF00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("en_in_ready", 32'(in_ready), 0);
      tick();
      chk("en_valid", 32'(out_valid), 1);
      chk("en_colour", 32'(colour_out), 4);
      chk("en_pix", 32'(pix_count), 3);
    end
    enable = 1'b1;
    tick();
    chk("en_resume", 32'(colour_out), 2);
    chk("en_resume_pix", 32'(pix_count), 4);
    in_valid = 1'b0;
    tick();

    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    rgb_in = 24'h808080; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_colour", 32'(colour_out4), 7);
    chk("sat_exact", 32'(exact4), 0);
    chk("sat_pix4", 32'(pix_count4), 15);
    chk("sat_inexact4", 32'(inexact_count4), 15);
    chk("wide_pix", 32'(pix_count), 20);
    chk("wide_inexact", 32'(inexact_count), 20);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0; in_valid = 1'b0;
    chk("clrwin_pix4", 32'(pix_count4), 0);
    chk("clrwin_inexact4", 32'(inexact_count4), 0);
    chk("clrwin_pix", 32'(pix_count), 0);
    chk("clrwin_data", 32'(out_valid), 1);
    tick();
    chk("clr_after", 32'(pix_count4), 0);

    rgb_in = 24'h00FFFF; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("ar_pre_valid", 32'(out_valid), 1);
    chk("ar_pre_pix", 32'(pix_count), 1);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_colour", 32'(colour_out), 0);
    chk("ar_pix", 32'(pix_count), 0);
    chk("ar_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    rgb_in = 24'hFF00FF; in_valid = 1'b1;
    tick();
    chk("ar_post_colour", 32'(colour_out), 5);
    chk("ar_post_exact", 32'(exact), 1);
    chk("ar_post_pix", 32'(pix_count), 1);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
